mem_stage_stack_seq: RTL and testbench

- Parametrised memory-stage block between EX/MEM and MEM/WB.
- Performs single-word loads/stores and single-word stack push/pop.
- Performs multi-beat stack save/restore of a PC_W-bit PC and FLAG_W-bit flags. Stalls upstream for the extra beats.
- Owns the data memory array and the stack pointer. Registers MEM/WB outputs with one-cycle latency.

---
 rtl/mem_stage_stack_seq.sv | 211 +++++++++++++++++++++
 tb/tb_mem_stage_stack_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_stack_seq.sv
// Memory stage: data memory, stack pointer, loads/stores, push/pop, multi-beat PC/flags save/restore.
// Latency: one cycle to out_data/out_dst/out_wb; restored PC/flags pulse at the edge ending the last beat.
// Backpressure: stall holds upstream during all but the final beat; optional STACK_GUARD_EN adds stack_err.
module mem_stage_stack_seq #(
    parameter int DATA_W    = 16,
    parameter int PC_W      = 32,
    parameter int FLAG_W    = 3,
    parameter int MEM_DEPTH = 4096,
    parameter int SP_INIT   = MEM_DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    input  logic                         mr,
    input  logic                         mw,
    input  logic                         wb_in,
    input  logic [2:0]                   dst_in,
    input  logic [$clog2(MEM_DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic                         jwsp,
    input  logic                         is_stack_op,
    input  logic                         stack_op,
    input  logic                         stack_pc,
    input  logic                         stack_flags,
    input  logic [PC_W-1:0]              pc_in,
    input  logic [FLAG_W-1:0]            flags_in,
    output logic                         stall,
    output logic [DATA_W-1:0]            out_data,
    output logic [2:0]                   out_dst,
    output logic                         out_wb,
    output logic [PC_W-1:0]              pc_out,
    output logic                         pc_valid,
    output logic [FLAG_W-1:0]            flags_out,
    output logic                         flags_valid,
    output logic [$clog2(MEM_DEPTH)-1:0] sp_out
`ifdef STACK_GUARD_EN
    ,
    output logic                         stack_err
`endif
);

    localparam int AW    = $clog2(MEM_DEPTH);
    localparam int BEATS = PC_W / DATA_W;
    localparam int CW    = $clog2(BEATS + 2);
    localparam logic [AW-1:0] SP_RST = AW'(SP_INIT);
    localparam logic [AW-1:0] SP_TOP = AW'(MEM_DEPTH - 1);
    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(MEM_DEPTH);

    typedef enum logic {IDLE, SEQ} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [AW-1:0]     sp, sp_nxt, sp_inc, sp_dec, acc_addr, addr_idx;
    logic [AW:0]       addr_ext;
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [DATA_W-1:0] rd_dat, wr_dat, flags_word, push_pc_word, result;
    logic [PC_W-1:0]   pc_sh, pc_nxt;
    logic [CW-1:0]     n_beats, beat, pc_k;
    logic              multi_req, single_req, single_stack, in_seq, active_multi;
    logic              last_beat, stack_acc, dir_pop, flag_beat, pc_beat;
    logic              guard_hit, mem_we, pop_done;

    always_comb begin
        addr_ext = {1'b0, addr};
        addr_idx = addr;
        if (addr_ext >= DEPTH_EXT) begin
            addr_idx = AW'(addr_ext - DEPTH_EXT);
        end
        sp_inc = (sp == SP_TOP) ? '0 : sp + AW'(1);
        sp_dec = (sp == '0) ? SP_TOP : sp - AW'(1);
    end

    // Sequence control: the beat index is 0 in the accepting (IDLE) cycle.
    always_comb begin
        n_beats = '0;
        if (stack_pc) begin
            n_beats = CW'(BEATS);
        end
        if (stack_flags) begin
            n_beats = n_beats + CW'(1);
        end
        in_seq       = (state == SEQ);
        multi_req    = req_valid && (stack_pc || stack_flags) && (mr || mw);
        single_req   = (state == IDLE) && req_valid && !stack_pc && !stack_flags;
        active_multi = in_seq || ((state == IDLE) && multi_req);
        single_stack = single_req && is_stack_op && (mr || mw);
        beat         = in_seq ? cnt : '0;
        last_beat    = (beat == n_beats - CW'(1));
        stack_acc    = active_multi || single_stack;
        dir_pop      = active_multi ? !mw : stack_op;
        flag_beat    = stack_flags && (mw ? (beat == '0) : last_beat);
        pc_beat      = active_multi && !flag_beat;
        pc_k         = stack_flags ? beat - CW'(1) : beat;
        pop_done     = active_multi && dir_pop && last_beat;
        stall        = !rst && active_multi && !last_beat;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (active_multi) begin
            if (last_beat) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                state_nxt = SEQ;
                cnt_nxt   = beat + CW'(1);
            end
        end
    end

    // Push order sends the most-significant PC word first.
    always_comb begin
        flags_word = '0;
        flags_word[FLAG_W-1:0] = flags_in;
        push_pc_word = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (pc_k == CW'(k)) begin
                push_pc_word = pc_in[(BEATS-1-k)*DATA_W +: DATA_W];
            end
        end
    end

`ifdef STACK_GUARD_EN
    assign guard_hit = stack_acc && (dir_pop ? (sp == SP_RST) : (sp == '0));
`else
    assign guard_hit = 1'b0;
`endif

    always_comb begin
        acc_addr = stack_acc ? (dir_pop ? sp_inc : sp) : addr_idx;
        rd_dat   = mem[acc_addr];
        wr_dat   = active_multi ? (flag_beat ? flags_word : push_pc_word) : wdata;
        mem_we   = !rst && !guard_hit && mw && (active_multi || single_req);
        sp_nxt   = (stack_acc && !guard_hit) ? (dir_pop ? sp_inc : sp_dec) : sp;
        result   = (mr && !jwsp && !mw) ? rd_dat : wdata;
    end

    // Popped PC words arrive least-significant first and shift in from the top.
    generate
        if (BEATS == 1) begin : g_pc_one
            assign pc_nxt = rd_dat;
        end else begin : g_pc_multi
            assign pc_nxt = {rd_dat, pc_sh[PC_W-1:DATA_W]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_addr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sp    <= SP_RST;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sp    <= sp_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data    <= '0;
            out_dst     <= '0;
            out_wb      <= 1'b0;
            pc_sh       <= '0;
            pc_out      <= '0;
            pc_valid    <= 1'b0;
            flags_out   <= '0;
            flags_valid <= 1'b0;
        end else begin
            out_wb      <= 1'b0;
            pc_valid    <= 1'b0;
            flags_valid <= 1'b0;
            if (single_req) begin
                out_data <= result;
                out_dst  <= dst_in;
                out_wb   <= wb_in;
            end
            if (active_multi && dir_pop && pc_beat) begin
                pc_sh <= pc_nxt;
            end
            if (pop_done && stack_pc) begin
                pc_out   <= flag_beat ? pc_sh : pc_nxt;
                pc_valid <= 1'b1;
            end
            if (pop_done && stack_flags) begin
                flags_out   <= rd_dat[FLAG_W-1:0];
                flags_valid <= 1'b1;
            end
        end
    end

`ifdef STACK_GUARD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stack_err <= 1'b0;
        end else if (guard_hit) begin
            stack_err <= 1'b1;
        end
    end
`endif

    assign sp_out = sp;

endmodule

// File: tb/tb_mem_stage_stack_seq.sv
// Directed bench for mem_stage_stack_seq with MEM_DEPTH=1024 (SP_INIT=1023).
module tb_mem_stage_stack_seq;

    logic        clk, rst, req_valid, mr, mw, wb_in, jwsp;
    logic        is_stack_op, stack_op, stack_pc, stack_flags;
    logic [2:0]  dst_in;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [31:0] pc_in;
    logic [2:0]  flags_in;
    logic        stall, out_wb, pc_valid, flags_valid;
    logic [15:0] out_data;
    logic [2:0]  out_dst;
    logic [31:0] pc_out;
    logic [2:0]  flags_out;
    logic [9:0]  sp_out;
`ifdef STACK_GUARD_EN
    logic        stack_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage_stack_seq #(.MEM_DEPTH(1024)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mr(mr), .mw(mw),
        .wb_in(wb_in), .dst_in(dst_in), .addr(addr), .wdata(wdata), .jwsp(jwsp),
        .is_stack_op(is_stack_op), .stack_op(stack_op), .stack_pc(stack_pc),
        .stack_flags(stack_flags), .pc_in(pc_in), .flags_in(flags_in),
        .stall(stall), .out_data(out_data), .out_dst(out_dst), .out_wb(out_wb),
        .pc_out(pc_out), .pc_valid(pc_valid), .flags_out(flags_out),
        .flags_valid(flags_valid), .sp_out(sp_out)
`ifdef STACK_GUARD_EN
        , .stack_err(stack_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        req_valid = 0; mr = 0; mw = 0; wb_in = 0; jwsp = 0; dst_in = 0;
        addr = 0; wdata = 0; is_stack_op = 0; stack_op = 0; stack_pc = 0;
        stack_flags = 0; pc_in = 0; flags_in = 0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear();
        rst = 1;
        tick(); tick();
        check("rst_out_data", out_data, 0);
        check("rst_out_dst", out_dst, 0);
        check("rst_out_wb", out_wb, 0);
        check("rst_pc_valid", pc_valid, 0);
        check("rst_flags_valid", flags_valid, 0);
        check("rst_sp", sp_out, 1023);
        check("rst_stall", stall, 0);
`ifdef STACK_GUARD_EN
        check("rst_stack_err", stack_err, 0);
`endif
        rst = 0;

        // Store then load
        req_valid = 1; mw = 1; addr = 5; wdata = 16'hBEEF;
        tick();
        mw = 0; mr = 1; wdata = 16'h1111; dst_in = 3; wb_in = 1;
        #1 check("load_stall", stall, 0);
        tick();
        check("load_data", out_data, 16'hBEEF);
        check("load_dst", out_dst, 3);
        check("load_wb", out_wb, 1);
        clear();
        tick();
        check("idle_wb", out_wb, 0);
        check("idle_data_hold", out_data, 16'hBEEF);
        check("idle_dst_hold", out_dst, 3);

        // Multi-beat push: flags, PC hi, PC lo
        req_valid = 1; mw = 1; stack_pc = 1; stack_flags = 1;
        pc_in = 32'h1234_5678; flags_in = 3'b101; wb_in = 1; dst_in = 6;
        #1 check("push_b0_stall", stall, 1);
        tick();
        check("push_b1_sp", sp_out, 1022);
        check("push_b1_stall", stall, 1);
        tick();
        check("push_b2_sp", sp_out, 1021);
        check("push_b2_stall", stall, 0);
        tick();
        clear();
        check("push_end_sp", sp_out, 1020);
        check("push_end_wb", out_wb, 0);
        check("push_end_dst_hold", out_dst, 3);
        req_valid = 1; mr = 1; addr = 1023;
        tick(); check("mem1023", out_data, 16'h0005);
        addr = 1022;
        tick(); check("mem1022", out_data, 16'h1234);
        addr = 1021;
        tick(); check("mem1021", out_data, 16'h5678);
        clear();

        // Multi-beat pop: PC lo, PC hi, flags
        req_valid = 1; mr = 1; stack_pc = 1; stack_flags = 1;
        #1 check("pop_b0_stall", stall, 1);
        tick();
        check("pop_b1_stall", stall, 1);
        check("pop_b1_pc_valid", pc_valid, 0);
        tick();
        check("pop_b2_stall", stall, 0);
        tick();
        clear();
        check("pop_pc_out", pc_out, 32'h1234_5678);
        check("pop_pc_valid", pc_valid, 1);
        check("pop_flags_out", flags_out, 3'b101);
        check("pop_flags_valid", flags_valid, 1);
        check("pop_sp", sp_out, 1023);
        tick();
        check("pop_pc_pulse_end", pc_valid, 0);
        check("pop_flags_pulse_end", flags_valid, 0);

        // Flags-only push and pop complete in one beat
        req_valid = 1; mw = 1; stack_flags = 1; flags_in = 3'b011;
        #1 check("fpush_stall", stall, 0);
        tick();
        clear();
        check("fpush_sp", sp_out, 1022);
        req_valid = 1; mr = 1; stack_flags = 1;
        #1 check("fpop_stall", stall, 0);
        tick();
        clear();
        check("fpop_flags_out", flags_out, 3'b011);
        check("fpop_flags_valid", flags_valid, 1);
        check("fpop_pc_valid", pc_valid, 0);
        check("fpop_sp", sp_out, 1023);

        // Save/restore request with neither mr nor mw is a NOP
        req_valid = 1; stack_pc = 1;
        #1 check("nop_stall", stall, 0);
        tick();
        clear();
        check("nop_sp", sp_out, 1023);

        // Single-word push and pop
        req_valid = 1; is_stack_op = 1; mw = 1; wdata = 16'h7777;
        tick();
        clear();
        check("spush_sp", sp_out, 1022);
        req_valid = 1; is_stack_op = 1; stack_op = 1; mr = 1; dst_in = 1; wb_in = 1;
        tick();
        clear();
        check("spop_data", out_data, 16'h7777);
        check("spop_wb", out_wb, 1);
        check("spop_sp", sp_out, 1023);

        // Reset during the second beat of a push
        req_valid = 1; mw = 1; stack_pc = 1; stack_flags = 1;
        pc_in = 32'hABCD_9876; flags_in = 3'b110;
        tick();
        check("rmid_b1_stall", stall, 1);
        clear();
        rst = 1;
        #1 check("rmid_rst_stall", stall, 0);
        tick();
        rst = 0;
        check("rmid_sp", sp_out, 1023);
        check("rmid_stall", stall, 0);
        check("rmid_pc_valid", pc_valid, 0);
        check("rmid_flags_valid", flags_valid, 0);
        tick();
        check("rmid_pc_valid2", pc_valid, 0);
        check("rmid_flags_valid2", flags_valid, 0);
        req_valid = 1; mr = 1; addr = 1023;
        tick();
        clear();
        check("rmid_mem1023", out_data, 16'h0006);

        // Result select
        req_valid = 1; mr = 1; jwsp = 1; addr = 5; wdata = 16'h00AA; dst_in = 2; wb_in = 1;
        tick();
        check("jwsp_data", out_data, 16'h00AA);
        check("jwsp_dst", out_dst, 2);
        jwsp = 0; mw = 1; addr = 7; wdata = 16'hC0DE; dst_in = 4;
        tick();
        check("mrmw_data", out_data, 16'hC0DE);
        check("mrmw_dst", out_dst, 4);
        mw = 0; wdata = 16'h0000;
        tick();
        clear();
        check("mrmw_written", out_data, 16'hC0DE);

        // Pop at SP_INIT: wrap or guard
        req_valid = 1; is_stack_op = 1; stack_op = 1; mr = 1;
        tick();
        clear();
`ifdef STACK_GUARD_EN
        check("guard_sp", sp_out, 1023);
        check("guard_err", stack_err, 1);
        tick();
        check("guard_err_sticky", stack_err, 1);
        rst = 1;
        tick();
        rst = 0;
        check("guard_err_rst", stack_err, 0);
        check("guard_rst_sp", sp_out, 1023);
`else
        check("wrap_pop_sp", sp_out, 0);
        req_valid = 1; is_stack_op = 1; mw = 1; wdata = 16'h0001;
        tick();
        clear();
        check("wrap_push_sp", sp_out, 1023);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
